draw_sprite: RTL and testbench
==============================

# draw_sprite

Pixel-pipeline stage placed directly downstream of the 800x600@60 timing generator (1056x628 total, 40 MHz pclk). It overlays a rectangular sprite, read from an external synchronous image ROM, onto the incoming VGA stream. It forwards every timing signal with a fixed matching delay. The sprite position is latched once per frame at the start of vertical blanking so the image never tears.

## Interface
Parameters:
- LOG2_W, 5, sprite width exponent; SPRITE_W = 2**LOG2_W (32 px)
- LOG2_H, 6, sprite height exponent; SPRITE_H = 2**LOG2_H (64 lines)
- TRANSPARENT, 12'hF0F, ROM colour treated as see-through

Ports:
- pclk  in  1  pixel clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- hcount_in  in  11  horizontal pixel counter, 0..1055
- hsync_in  in  1  horizontal sync
- hblnk_in  in  1  horizontal blank
- vcount_in  in  11  vertical line counter, 0..627
- vsync_in  in  1  vertical sync
- vblnk_in  in  1  vertical blank
- rgb_in  in  12  background colour, 4:4:4
- xpos  in  11  sprite left column request
- ypos  in  11  sprite top line request
- show  in  1  sprite enable request
- rom_addr  out  LOG2_W+LOG2_H  ROM address {row, col}, registered
- rom_data  in  12  ROM pixel; valid one pclk after rom_addr (synchronous ROM)
- hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out, rgb_out  out  widths as inputs  delayed and overlaid stream

## Operation
- Frame latch:
  - The block keeps vblnk_prev, the previous value of vblnk_in.
  - On any cycle where vblnk_in=1 and vblnk_prev=0, it captures xpos, ypos and show into xpos_q, ypos_q and show_q.
  - Requests change nowhere else.
- Hit test, stage 1, uses 12-bit arithmetic so the sum never wraps:
  - hit = show_q && !hblnk_in && !vblnk_in
  - && hcount_in >= xpos_q && hcount_in < xpos_q + SPRITE_W
  - && vcount_in >= ypos_q && vcount_in < ypos_q + SPRITE_H.
- Address:
  - When hit, rom_addr = {(vcount_in-ypos_q)[LOG2_H-1:0], (hcount_in-xpos_q)[LOG2_W-1:0]}.
  - Otherwise rom_addr = 0.
- Pipeline: three register stages (S1, S2, S3) carry all seven stream signals plus the hit flag.
- Output mux at S3:
  - rgb_out = rom_data when hit_s2=1 and rom_data != TRANSPARENT.
  - Otherwise rgb_out = rgb of S2, i.e. the background passes through.
- Clipping:
  - A sprite extending past column 799 or line 599 is clipped, because hit is forced 0 in blanking.
  - There is no wrap to column 0.
- No per-pixel state beyond the pipeline. The block never stalls and has no handshake; the ROM read is fire-and-forget.

## Timing
- Latency: 3 pclk for every output. The value on the inputs before edge k appears on the outputs after edge k+2.
- rom_addr is presented after edge k; rom_data is consumed at edge k+2.
- All timing outputs are mutually aligned, with exactly the same relationships as the inputs.
- Reset, asynchronous on rst=1 (also applies mid-frame):
  - All outputs, rom_addr, pipeline stages, hit flags, xpos_q, ypos_q, show_q and vblnk_prev go to 0.
  - No sprite is drawn until the first vblank rising edge after reset release.
  - If vblnk_in=1 on the first post-reset edge, that edge counts as rising.
- Requests that change mid-frame take effect at the next vblank rising edge only.
- Boundary conditions:
  - xpos_q=0 hits from column 0.
  - xpos_q=768 hits columns 768..799.
  - xpos_q >= 800 never hits.
  - xpos_q + SPRITE_W is computed in 12 bits, so xpos_q=2047 does not alias.

## Test plan
- Passthrough: show=0, arbitrary rgb_in ramp -> every output equals its input delayed exactly 3 pclk; rom_addr stays 0.
- Placement: xpos=100, ypos=50, show=1 latched at a vblank edge, ROM returning address-coded colours. Expected:
  - Pixel (100,50) -> rgb_out=ROM[0].
  - Pixel (131,113) -> ROM[{6'd63,5'd31}].
  - Pixels (99,50) and (132,50) -> background.
- Transparency: ROM word = 12'hF0F inside the window -> rgb_out equals rgb_in delayed; neighbouring 12'h123 -> 12'h123.
- Frame latch: change xpos from 100 to 300 at line 200 -> the rest of that frame is still drawn at 100; the next frame is drawn at 300, switching exactly at the vblnk_in rise at line 600.
- Clipping: xpos=780, ypos=580 -> the sprite is drawn only on columns 780..799 and lines 580..599; outputs during blank equal background; no hit at column 0 of the next line.
- Reset mid-frame: assert rst at line 300 for 5 cycles -> all outputs 0 immediately and asynchronously; after release the sprite stays hidden until the next vblank rising edge, then appears at the current request.

Source files
------------

// File: rtl/draw_sprite_if.sv
// rtl/draw_sprite_if.sv - VGA pixel stream bundle shared by the timing chain
//
// Carries one pixel's worth of timing plus colour.
//   hcount 11  horizontal pixel counter
//   hsync   1  horizontal sync
//   hblnk   1  horizontal blank
//   vcount 11  vertical line counter
//   vsync   1  vertical sync
//   vblnk   1  vertical blank
//   rgb    12  colour, 4:4:4
// master drives the stream, slave receives it.
interface draw_sprite_if;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [11:0] rgb;

  modport master (output hcount, hsync, hblnk, vcount, vsync, vblnk, rgb);
  modport slave  (input  hcount, hsync, hblnk, vcount, vsync, vblnk, rgb);
endinterface

// File: rtl/draw_sprite.sv
// rtl/draw_sprite.sv - overlays a ROM-backed sprite onto the VGA stream
//
// Three-stage pipeline: every stream signal is delayed exactly 3 pclk.
// Ports:
//   pclk, rst        pixel clock, asynchronous active-high reset
//   vga_in  (slave)  incoming timing + background colour
//   vga_out (master) delayed timing + overlaid colour
//   xpos, ypos, show sprite position/enable requests, sampled at vblank rise
//   rom_addr         registered {row, col} address into the sprite ROM
//   rom_data         ROM word, valid one pclk after rom_addr
module draw_sprite #(
  parameter int          LOG2_W      = 5,
  parameter int          LOG2_H      = 6,
  parameter logic [11:0] TRANSPARENT = 12'hF0F
) (
  input  logic                     pclk,
  input  logic                     rst,
  draw_sprite_if.slave             vga_in,
  draw_sprite_if.master            vga_out,
  input  logic [10:0]              xpos,
  input  logic [10:0]              ypos,
  input  logic                     show,
  output logic [LOG2_W+LOG2_H-1:0] rom_addr,
  input  logic [11:0]              rom_data
);

  localparam logic [11:0] SPRITE_W = 12'(2 ** LOG2_W);
  localparam logic [11:0] SPRITE_H = 12'(2 ** LOG2_H);

  typedef struct packed {
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [11:0] rgb;
  } stream_t;

  stream_t in_s, s1, s2, out_q;

  logic        vblnk_prev;
  logic [10:0] xpos_q, ypos_q;
  logic        show_q;
  logic        hit, hit_s1, hit_s2;

  assign in_s = {vga_in.hcount, vga_in.hsync, vga_in.hblnk,
                 vga_in.vcount, vga_in.vsync, vga_in.vblnk, vga_in.rgb};

  // 12-bit compare so xpos_q + SPRITE_W cannot wrap back to column 0.
  logic [11:0] h12, v12, x12, y12;
  assign h12 = {1'b0, vga_in.hcount};
  assign v12 = {1'b0, vga_in.vcount};
  assign x12 = {1'b0, xpos_q};
  assign y12 = {1'b0, ypos_q};

  // Blanking gate doubles as the right/bottom clip.
  assign hit = show_q && !vga_in.hblnk && !vga_in.vblnk &&
               (h12 >= x12) && (h12 < x12 + SPRITE_W) &&
               (v12 >= y12) && (v12 < y12 + SPRITE_H);

  logic [LOG2_W-1:0] col;
  logic [LOG2_H-1:0] row;
  assign col = LOG2_W'(h12 - x12);
  assign row = LOG2_H'(v12 - y12);

  // rom_data lines up with S2: address issued at S1, ROM registers it one cycle later.
  logic [11:0] rgb_mux;
  assign rgb_mux = (hit_s2 && rom_data != TRANSPARENT) ? rom_data : s2.rgb;

  // Position is only taken at vblank rise so a frame is never drawn half-moved.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vblnk_prev <= 1'b0;
      xpos_q     <= '0;
      ypos_q     <= '0;
      show_q     <= 1'b0;
    end else begin
      vblnk_prev <= vga_in.vblnk;
      if (vga_in.vblnk && !vblnk_prev) begin
        xpos_q <= xpos;
        ypos_q <= ypos;
        show_q <= show;
      end
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      s1       <= '0;
      s2       <= '0;
      out_q    <= '0;
      hit_s1   <= 1'b0;
      hit_s2   <= 1'b0;
      rom_addr <= '0;
    end else begin
      s1       <= in_s;
      hit_s1   <= hit;
      rom_addr <= hit ? {row, col} : '0;
      s2       <= s1;
      hit_s2   <= hit_s1;
      out_q    <= {s2.hcount, s2.hsync, s2.hblnk,
                   s2.vcount, s2.vsync, s2.vblnk, rgb_mux};
    end
  end

  assign vga_out.hcount = out_q.hcount;
  assign vga_out.hsync  = out_q.hsync;
  assign vga_out.hblnk  = out_q.hblnk;
  assign vga_out.vcount = out_q.vcount;
  assign vga_out.vsync  = out_q.vsync;
  assign vga_out.vblnk  = out_q.vblnk;
  assign vga_out.rgb    = out_q.rgb;

endmodule

// File: tb/tb_draw_sprite.sv
// tb/tb_draw_sprite.sv - directed self-checking bench for draw_sprite
module tb_draw_sprite;
  logic        pclk = 1'b0;
  logic        rst;
  logic [10:0] xpos, ypos;
  logic        show;
  logic [10:0] rom_addr;
  logic [11:0] rom_data = '0;

  int total = 0;
  int bad   = 0;

  draw_sprite_if vin();
  draw_sprite_if vout();

  draw_sprite dut (
    .pclk     (pclk),
    .rst      (rst),
    .vga_in   (vin),
    .vga_out  (vout),
    .xpos     (xpos),
    .ypos     (ypos),
    .show     (show),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );

  always #5 pclk = ~pclk;

  // Address-coded sprite image with one see-through word and one fixed neighbour.
  function automatic logic [11:0] rom_fn(input logic [10:0] a);
    if (a == 11'd330)      return 12'hF0F;
    else if (a == 11'd331) return 12'h123;
    else                   return {1'b0, a};
  endfunction

  always @(posedge pclk) rom_data <= rom_fn(rom_addr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [10:0] h, input logic [10:0] v, input logic hs,
                        input logic hb, input logic vs, input logic vb, input logic [11:0] rgb);
    vin.hcount = h;  vin.vcount = v;
    vin.hsync  = hs; vin.hblnk  = hb;
    vin.vsync  = vs; vin.vblnk  = vb;
    vin.rgb    = rgb;
  endtask

  task automatic step(input logic [10:0] h, input logic [10:0] v, input logic hb, input logic vb);
    set_in(h, v, 1'b0, hb, 1'b0, vb, 12'h0F0);
    @(posedge pclk); #1;
  endtask

  // One pixel, then two distinct fillers, so the pixel must emerge exactly 3 edges later.
  task automatic probe(input string tag, input logic [10:0] h, input logic [10:0] v,
                       input logic hs, input logic hb, input logic vs, input logic vb,
                       input logic [11:0] rgb, input logic [10:0] exp_addr,
                       input logic [11:0] exp_rgb);
    set_in(h, v, hs, hb, vs, vb, rgb);
    @(posedge pclk); #1;
    chk({tag, "_addr"}, 64'(rom_addr), 64'(exp_addr));
    set_in(11'd1000, 11'd10, 1'b1, 1'b1, 1'b0, 1'b0, 12'h0F0);
    @(posedge pclk); #1;
    set_in(11'd1001, 11'd11, 1'b0, 1'b1, 1'b1, 1'b0, 12'h00F);
    @(posedge pclk); #1;
    chk({tag, "_out"},
        64'({vout.hcount, vout.hsync, vout.hblnk, vout.vcount, vout.vsync, vout.vblnk, vout.rgb}),
        64'({h, hs, hb, v, vs, vb, exp_rgb}));
  endtask

  task automatic px(input string tag, input logic [10:0] h, input logic [10:0] v,
                    input logic [10:0] exp_addr, input logic [11:0] exp_rgb);
    probe(tag, h, v, 1'b0, 1'b0, 1'b0, 1'b0, 12'hA5A, exp_addr, exp_rgb);
  endtask

  task automatic latch(input logic [10:0] x, input logic [10:0] y, input logic s);
    xpos = x; ypos = y; show = s;
    set_in(11'd0, 11'd600, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
    @(posedge pclk); #1;
  endtask

  task automatic chk_zero(input string tag);
    chk(tag,
        64'({vout.hcount, vout.hsync, vout.hblnk, vout.vcount, vout.vsync, vout.vblnk, vout.rgb, rom_addr}),
        64'(0));
  endtask

  initial begin
    rst  = 1'b1;
    xpos = 11'd100; ypos = 11'd50; show = 1'b1;
    set_in(11'd5, 11'd6, 1'b1, 1'b1, 1'b1, 1'b0, 12'hABC);
    repeat (3) @(posedge pclk);
    #1;
    chk_zero("reset_state");
    @(negedge pclk) rst = 1'b0;
    @(posedge pclk); #1;

    // Passthrough: request is pending but not yet latched.
    probe("pass_a", 11'd100, 11'd50, 1'b0, 1'b0, 1'b0, 1'b0, 12'h5A5, 11'd0, 12'h5A5);
    probe("pass_b", 11'd1055, 11'd627, 1'b1, 1'b1, 1'b1, 1'b0, 12'h7E1, 11'd0, 12'h7E1);

    // Placement
    latch(11'd100, 11'd50, 1'b1);
    px("pl_origin", 11'd100, 11'd50, 11'd0, 12'h000);
    px("pl_corner", 11'd131, 11'd113, 11'd2047, 12'h7FF);
    px("pl_left",   11'd99,  11'd50, 11'd0, 12'hA5A);
    px("pl_right",  11'd132, 11'd50, 11'd0, 12'hA5A);
    px("pl_below",  11'd131, 11'd114, 11'd0, 12'hA5A);
    px("pl_mid",    11'd105, 11'd52, 11'd69, 12'h045);

    // Transparency
    px("tr_key",   11'd110, 11'd60, 11'd330, 12'hA5A);
    px("tr_neigh", 11'd111, 11'd60, 11'd331, 12'h123);

    // Frame latch: mid-frame request change is ignored until vblank rise
    xpos = 11'd300;
    px("fl_old_pos", 11'd100, 11'd60, 11'd320, 12'h140);
    px("fl_new_pos", 11'd300, 11'd60, 11'd0, 12'hA5A);
    latch(11'd300, 11'd50, 1'b1);
    xpos = 11'd500;
    step(11'd1, 11'd600, 1'b0, 1'b1);
    px("fl_switched", 11'd300, 11'd60, 11'd320, 12'h140);
    px("fl_no_relatch", 11'd500, 11'd60, 11'd0, 12'hA5A);
    px("fl_old_gone", 11'd100, 11'd60, 11'd0, 12'hA5A);

    // Clipping
    latch(11'd780, 11'd580, 1'b1);
    px("cl_origin", 11'd780, 11'd580, 11'd0, 12'h000);
    px("cl_edge",   11'd799, 11'd599, 11'd627, 12'h273);
    probe("cl_hblank", 11'd800, 11'd599, 1'b0, 1'b1, 1'b0, 1'b0, 12'h3C3, 11'd0, 12'h3C3);
    probe("cl_vblank", 11'd785, 11'd600, 1'b0, 1'b0, 1'b0, 1'b1, 12'h3C4, 11'd0, 12'h3C4);
    px("cl_nowrap", 11'd0, 11'd581, 11'd0, 12'hA5A);
    px("cl_before", 11'd779, 11'd590, 11'd0, 12'hA5A);

    // Column boundaries
    latch(11'd0, 11'd0, 1'b1);
    px("bd_x0_c0",  11'd0,  11'd0, 11'd0,  12'h000);
    px("bd_x0_c31", 11'd31, 11'd0, 11'd31, 12'h01F);
    px("bd_x0_c32", 11'd32, 11'd0, 11'd0,  12'hA5A);
    latch(11'd768, 11'd0, 1'b1);
    px("bd_x768_c799", 11'd799, 11'd0, 11'd31, 12'h01F);
    px("bd_x768_c767", 11'd767, 11'd0, 11'd0, 12'hA5A);
    latch(11'd800, 11'd0, 1'b1);
    probe("bd_x800", 11'd800, 11'd0, 1'b0, 1'b1, 1'b0, 1'b0, 12'hA5A, 11'd0, 12'hA5A);
    latch(11'd2047, 11'd0, 1'b1);
    px("bd_x2047_c0",  11'd0,  11'd0, 11'd0, 12'hA5A);
    px("bd_x2047_c30", 11'd30, 11'd0, 11'd0, 12'hA5A);

    // Reset mid-frame
    latch(11'd100, 11'd50, 1'b1);
    step(11'd100, 11'd50, 1'b0, 1'b0);
    step(11'd101, 11'd50, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1 chk_zero("rst_async");
    set_in(11'd400, 11'd300, 1'b0, 1'b0, 1'b0, 1'b0, 12'h777);
    repeat (5) @(posedge pclk);
    #1 chk_zero("rst_held");
    @(negedge pclk) rst = 1'b0;
    xpos = 11'd200;
    @(posedge pclk); #1;
    px("rst_hidden_old", 11'd100, 11'd50, 11'd0, 12'hA5A);
    px("rst_hidden_new", 11'd200, 11'd50, 11'd0, 12'hA5A);
    latch(11'd200, 11'd50, 1'b1);
    px("rst_shown", 11'd200, 11'd50, 11'd0, 12'h000);
    px("rst_old_gone", 11'd100, 11'd50, 11'd0, 12'hA5A);

    // vblnk already high on the first edge after reset counts as a rise
    set_in(11'd0, 11'd610, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
    xpos = 11'd400; ypos = 11'd50; show = 1'b1;
    @(negedge pclk) rst = 1'b1;
    @(negedge pclk) rst = 1'b0;
    @(posedge pclk); #1;
    px("rst_vb_first", 11'd400, 11'd50, 11'd0, 12'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
